// File: rtl/grn_wr_engine_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : grn_wr_engine_if
//  Purpose  : Block-input and CCI-P C1 write-channel bundle of the GRN write
//             engine.
//             master = write engine; slave = compute core / host-side model.
//  Signals  : in_valid/in_data/in_ready   block stream from the compute core
//             wr_valid/wr_addr/wr_data/wr_mdata   C1 write request
//             wr_almost_full   C1 TX back-pressure
//             wr_rsp_valid     one C1 write response
//  Revision : 1.0  initial release
// ============================================================================
interface grn_wr_engine_if;
    logic         in_valid;
    logic [511:0] in_data;
    logic         in_ready;
    logic         wr_valid;
    logic [41:0]  wr_addr;
    logic [511:0] wr_data;
    logic [15:0]  wr_mdata;
    logic         wr_almost_full;
    logic         wr_rsp_valid;

    modport master (
        input  in_valid, in_data, wr_almost_full, wr_rsp_valid,
        output in_ready, wr_valid, wr_addr, wr_data, wr_mdata
    );

    modport slave (
        output in_valid, in_data, wr_almost_full, wr_rsp_valid,
        input  in_ready, wr_valid, wr_addr, wr_data, wr_mdata
    );
endinterface
`default_nettype wire

// File: rtl/grn_wr_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : grn_wr_engine
//  Purpose  : Host-memory write stage of the GRN accelerator. Drains 512-bit
//             result blocks into the host buffer (one cache line each) on the
//             C1 write channel, then writes a completion line to the DSM and
//             pulses done once its response returns.
//  Ports    : clk, reset (sync, active-high)
//             start, buf_addr, buf_size, dsm_addr : job arming, sampled on an
//                                                   accepted start
//             bus (master)                        : block input + C1 writes
//             busy, done                          : status
//  Revision : 1.0  initial release
// ============================================================================
module grn_wr_engine #(
    parameter int          MAX_OUTSTANDING = 64,
    parameter logic [15:0] MDATA_TAG       = 16'h0001
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        start,
    input  wire logic [63:0] buf_addr,
    input  wire logic [31:0] buf_size,
    input  wire logic [63:0] dsm_addr,
    grn_wr_engine_if.master  bus,
    output logic             busy,
    output logic             done
);
    localparam int                 c_out_w   = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [c_out_w-1:0] c_max_out = c_out_w'(MAX_OUTSTANDING);
    localparam logic [c_out_w-1:0] c_one     = c_out_w'(1);

    localparam logic [1:0] S_WR_IDLE     = 2'd0;
    localparam logic [1:0] S_WR_DATA     = 2'd1;
    localparam logic [1:0] S_WR_FINISH_1 = 2'd2;
    localparam logic [1:0] S_WR_FINISH_2 = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [41:0]        r_base_cl;
    logic [41:0]        r_dsm_cl;
    logic [31:0]        r_size;
    logic [31:0]        r_sent;
    logic [c_out_w-1:0] r_outstanding;
    logic               r_dsm_issued;
    logic               r_wr_valid;
    logic [41:0]        r_wr_addr;
    logic [511:0]       r_wr_data;
    logic               r_done;

    logic w_in_ready;
    logic w_start_take;
    logic w_dsm_issue;
    logic w_done_evt;
    logic w_accept;
    logic w_issue;
    logic w_rsp_take;
    logic w_unused;

    // Only the cache-line field [47:6] of the byte addresses is meaningful.
    assign w_unused = ^{buf_addr[63:48], buf_addr[5:0], dsm_addr[63:48], dsm_addr[5:0]};

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_WR_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_start_take = 1'b0;
        w_dsm_issue  = 1'b0;
        w_done_evt   = 1'b0;
        case (r_state)
            S_WR_IDLE: begin
                if (start) begin
                    w_start_take = 1'b1;
                    w_next_state = (buf_size != 32'd0) ? S_WR_DATA : S_WR_FINISH_1;
                end
            end
            S_WR_DATA: begin
                w_in_ready = !bus.wr_almost_full && (r_outstanding < c_max_out) &&
                             (r_sent < r_size);
                if (w_in_ready && bus.in_valid && ((r_sent + 32'd1) == r_size))
                    w_next_state = S_WR_FINISH_1;
            end
            S_WR_FINISH_1: begin
                if (r_outstanding == '0)
                    w_next_state = S_WR_FINISH_2;
            end
            S_WR_FINISH_2: begin
                w_dsm_issue = !r_dsm_issued && !bus.wr_almost_full;
                // Buffer writes are all acknowledged here, so the only
                // response left is the DSM write's.
                if (r_dsm_issued && w_rsp_take) begin
                    w_done_evt   = 1'b1;
                    w_next_state = S_WR_IDLE;
                end
            end
            default: w_next_state = S_WR_IDLE;
        endcase
    end

    assign w_accept   = w_in_ready && bus.in_valid;
    assign w_issue    = w_accept || w_dsm_issue;
    // Responses with nothing outstanding (e.g. stale ones after reset) are dropped.
    assign w_rsp_take = bus.wr_rsp_valid && (r_outstanding != '0);

    // A write is counted as outstanding from the cycle it is committed to the
    // output register, so the slot limit already covers the write that will
    // appear on the bus next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_base_cl     <= '0;
            r_dsm_cl      <= '0;
            r_size        <= '0;
            r_sent        <= '0;
            r_outstanding <= '0;
            r_dsm_issued  <= 1'b0;
            r_wr_valid    <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_done        <= 1'b0;
        end else begin
            r_wr_valid <= w_issue;
            r_done     <= w_done_evt;
            if (w_start_take) begin
                r_base_cl    <= buf_addr[47:6];
                r_dsm_cl     <= dsm_addr[47:6];
                r_size       <= buf_size;
                r_sent       <= '0;
                r_dsm_issued <= 1'b0;
            end
            if (w_accept) begin
                r_wr_addr <= r_base_cl + {10'd0, r_sent};
                r_wr_data <= bus.in_data;
                r_sent    <= r_sent + 32'd1;
            end
            if (w_dsm_issue) begin
                r_wr_addr    <= r_dsm_cl;
                r_wr_data    <= {448'd0, r_sent, 32'd1};
                r_dsm_issued <= 1'b1;
            end
            if (w_issue && !w_rsp_take)
                r_outstanding <= r_outstanding + c_one;
            else if (!w_issue && w_rsp_take)
                r_outstanding <= r_outstanding - c_one;
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.wr_valid = r_wr_valid;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign bus.wr_mdata = MDATA_TAG;
    assign busy         = (r_state != S_WR_IDLE);
    assign done         = r_done;
endmodule
`default_nettype wire

// File: tb/tb_grn_wr_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_grn_wr_engine
//  Purpose  : Directed self-checking bench for grn_wr_engine (built with
//             MAX_OUTSTANDING = 2 so slot limits are reachable).
//  Revision : 1.0  initial release
// ============================================================================
module tb_grn_wr_engine;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [63:0] buf_addr = '0;
    logic [31:0] buf_size = '0;
    logic [63:0] dsm_addr = '0;
    logic        busy;
    logic        done;

    grn_wr_engine_if bus ();

    grn_wr_engine #(.MAX_OUTSTANDING(2), .MDATA_TAG(16'h0001)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .buf_addr (buf_addr),
        .buf_size (buf_size),
        .dsm_addr (dsm_addr),
        .bus      (bus.master),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Host model state: written only by the monitor below.
    logic [41:0]  wa[$];
    logic [511:0] wd[$];
    int wcount = 0, rsp_sent = 0, done_cnt = 0, rel_done = 0, stray_done = 0;
    // Host model controls: written only by the test tasks.
    bit auto_rsp = 1'b1;
    int rel_total = 0, stray_total = 0, rsp_floor = 0;

    function automatic logic [511:0] make_blk(input int k);
        logic [31:0] w;
        w = 32'hB10C_0000 ^ 32'(k);
        return {16{w}};
    endfunction

    // Records every write, counts done pulses, returns responses and presents
    // block number <writes so far> on the input (an accepted block always
    // becomes visible as a write before the next accept).
    always @(negedge clk) begin
        if (bus.wr_valid) begin
            wa.push_back(bus.wr_addr);
            wd.push_back(bus.wr_data);
            wcount++;
        end
        if (done) done_cnt++;
        if (rsp_sent < rsp_floor) rsp_sent = rsp_floor;
        bus.in_data = make_blk(wcount);
        if (stray_total > stray_done) begin
            bus.wr_rsp_valid = 1'b1;
            stray_done++;
        end else if ((wcount > rsp_sent) && (auto_rsp || (rel_total > rel_done))) begin
            bus.wr_rsp_valid = 1'b1;
            rsp_sent++;
            if (!auto_rsp) rel_done++;
        end else begin
            bus.wr_rsp_valid = 1'b0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(input logic [63:0] b, input logic [31:0] s, input logic [63:0] d);
        tick();
        buf_addr = b; buf_size = s; dsm_addr = d; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (done_cnt > d0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.wr_almost_full = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
        n_cmp++; if (bus.wr_valid !== 1'b0) begin n_err++; $display("FAIL rst_wr_valid got %b want 0", bus.wr_valid); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (bus.wr_addr !== 42'h0) begin n_err++; $display("FAIL rst_wr_addr got %h want 0", bus.wr_addr); end
        n_cmp++; if (bus.wr_data !== 512'h0) begin n_err++; $display("FAIL rst_wr_data got nonzero want 0"); end
        n_cmp++; if (bus.wr_mdata !== 16'h0001) begin n_err++; $display("FAIL mdata got %h want 0001", bus.wr_mdata); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int w0, d0; bit ok;
        w0 = wcount; d0 = done_cnt; auto_rsp = 1'b1; bus.in_valid = 1'b1;
        do_start(64'h1000, 32'd4, 64'h8000);
        wait_done(d0, 200, ok);
        bus.in_valid = 1'b0;
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL basic_done_seen got %b want 1", ok); end
        n_cmp++; if (wcount - w0 != 5) begin n_err++; $display("FAIL basic_write_count got %0d want 5", wcount - w0); end
        if (wcount - w0 == 5) begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++; if (wa[w0+k] !== 42'h40 + 42'(k)) begin n_err++; $display("FAIL basic_addr[%0d] got %h want %h", k, wa[w0+k], 42'h40 + 42'(k)); end
                n_cmp++; if (wd[w0+k] !== make_blk(w0 + k)) begin n_err++; $display("FAIL basic_data[%0d] got %h want %h", k, wd[w0+k][31:0], make_blk(w0 + k)[31:0]); end
            end
            n_cmp++; if (wa[w0+4] !== 42'h200) begin n_err++; $display("FAIL basic_dsm_addr got %h want 200", wa[w0+4]); end
            n_cmp++; if (wd[w0+4][63:0] !== 64'h0000_0004_0000_0001) begin n_err++; $display("FAIL basic_dsm_data got %h want 0000000400000001", wd[w0+4][63:0]); end
            n_cmp++; if (wd[w0+4][511:64] !== 448'h0) begin n_err++; $display("FAIL basic_dsm_upper got nonzero want 0"); end
        end
        repeat (5) tick();
        n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt - d0); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after got %b want 0", busy); end
    endtask

    task automatic test_size_zero();
        int w0, d0; bit ok;
        w0 = wcount; d0 = done_cnt; auto_rsp = 1'b1; bus.in_valid = 1'b1;
        do_start(64'h2000, 32'd0, 64'h8040);
        wait_done(d0, 100, ok);
        bus.in_valid = 1'b0;
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL zero_done_seen got %b want 1", ok); end
        n_cmp++; if (wcount - w0 != 1) begin n_err++; $display("FAIL zero_write_count got %0d want 1", wcount - w0); end
        if (wcount - w0 == 1) begin
            n_cmp++; if (wa[w0] !== 42'h201) begin n_err++; $display("FAIL zero_dsm_addr got %h want 201", wa[w0]); end
            n_cmp++; if (wd[w0][63:0] !== 64'h1) begin n_err++; $display("FAIL zero_dsm_data got %h want 1", wd[w0][63:0]); end
        end
    endtask

    task automatic test_af_toggle();
        int w0, d0, viol; bit ok;
        w0 = wcount; d0 = done_cnt; viol = 0; ok = 1'b0; auto_rsp = 1'b1; bus.in_valid = 1'b1;
        do_start(64'h4000, 32'd8, 64'h8080);
        for (int i = 0; i < 300 && !ok; i++) begin
            tick();
            bus.wr_almost_full = (i % 2) == 1;
            #1;
            if (bus.wr_almost_full && bus.in_ready) viol++;
            if (done_cnt > d0) ok = 1'b1;
        end
        bus.wr_almost_full = 1'b0; bus.in_valid = 1'b0;
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL af_done_seen got %b want 1", ok); end
        n_cmp++; if (viol != 0) begin n_err++; $display("FAIL af_ready_while_af got %0d want 0", viol); end
        n_cmp++; if (wcount - w0 != 9) begin n_err++; $display("FAIL af_write_count got %0d want 9", wcount - w0); end
        if (wcount - w0 == 9) begin
            for (int k = 0; k < 8; k++) begin
                n_cmp++; if (wa[w0+k] !== 42'h100 + 42'(k) || wd[w0+k] !== make_blk(w0 + k)) begin n_err++; $display("FAIL af_order[%0d] got addr %h want %h", k, wa[w0+k], 42'h100 + 42'(k)); end
            end
            n_cmp++; if (wd[w0+8][63:0] !== 64'h0000_0008_0000_0001) begin n_err++; $display("FAIL af_dsm_data got %h want 0000000800000001", wd[w0+8][63:0]); end
        end
    endtask

    task automatic test_max_outstanding();
        int w0, d0; bit ok;
        w0 = wcount; d0 = done_cnt; auto_rsp = 1'b0; bus.in_valid = 1'b1;
        do_start(64'h10000, 32'd4, 64'h80C0);
        repeat (10) tick();
        n_cmp++; if (wcount - w0 != 2) begin n_err++; $display("FAIL max_stall_count got %0d want 2", wcount - w0); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL max_stall_ready got %b want 0", bus.in_ready); end
        rel_total++; repeat (6) tick();
        n_cmp++; if (wcount - w0 != 3) begin n_err++; $display("FAIL max_rel1_count got %0d want 3", wcount - w0); end
        rel_total++; repeat (6) tick();
        n_cmp++; if (wcount - w0 != 4) begin n_err++; $display("FAIL max_rel2_count got %0d want 4", wcount - w0); end
        rel_total++; repeat (6) tick();
        n_cmp++; if (wcount - w0 != 4) begin n_err++; $display("FAIL max_finish_wait got %0d want 4", wcount - w0); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL max_finish_busy got %b want 1", busy); end
        rel_total++; repeat (6) tick();
        n_cmp++; if (wcount - w0 != 5) begin n_err++; $display("FAIL max_dsm_issue got %0d want 5", wcount - w0); end
        if (wcount - w0 == 5) begin
            n_cmp++; if (wa[w0+4] !== 42'h203) begin n_err++; $display("FAIL max_dsm_addr got %h want 203", wa[w0+4]); end
            n_cmp++; if (wa[w0+3] !== 42'h403) begin n_err++; $display("FAIL max_last_addr got %h want 403", wa[w0+3]); end
        end
        n_cmp++; if (done_cnt != d0) begin n_err++; $display("FAIL max_early_done got %0d want %0d", done_cnt, d0); end
        rel_total++;
        wait_done(d0, 50, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL max_done_seen got %b want 1", ok); end
        bus.in_valid = 1'b0; auto_rsp = 1'b1;
    endtask

    task automatic test_back_to_back();
        int w0, d0, viol; bit ok, sent2;
        w0 = wcount; d0 = done_cnt; viol = 0; ok = 1'b0; sent2 = 1'b0;
        auto_rsp = 1'b1; bus.in_valid = 1'b1;
        do_start(64'h20000, 32'd6, 64'h8100);
        for (int i = 0; i < 300 && !ok; i++) begin
            tick();
            start = 1'b0;
            if (dut.r_outstanding > 2'd2) viol++;
            if (!sent2 && (wcount - w0 >= 2)) begin
                buf_addr = 64'hF000; buf_size = 32'd1; dsm_addr = 64'h9000; start = 1'b1; sent2 = 1'b1;
            end
            if (done_cnt > d0) ok = 1'b1;
        end
        start = 1'b0; bus.in_valid = 1'b0;
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL b2b_done_seen got %b want 1", ok); end
        n_cmp++; if (viol != 0) begin n_err++; $display("FAIL b2b_outstanding_limit got %0d want 0", viol); end
        n_cmp++; if (wcount - w0 != 7) begin n_err++; $display("FAIL b2b_write_count got %0d want 7", wcount - w0); end
        if (wcount - w0 == 7) begin
            for (int k = 0; k < 6; k++) begin
                n_cmp++; if (wa[w0+k] !== 42'h800 + 42'(k)) begin n_err++; $display("FAIL b2b_addr[%0d] got %h want %h", k, wa[w0+k], 42'h800 + 42'(k)); end
            end
            n_cmp++; if (wa[w0+6] !== 42'h204 || wd[w0+6][63:0] !== 64'h0000_0006_0000_0001) begin n_err++; $display("FAIL b2b_dsm got %h/%h want 204/0000000600000001", wa[w0+6], wd[w0+6][63:0]); end
        end
        tick();
        n_cmp++; if (dut.r_outstanding !== 2'd0) begin n_err++; $display("FAIL b2b_outstanding_end got %0d want 0", dut.r_outstanding); end
    endtask

    task automatic test_reset_mid();
        int w0, d0; bit ok, hit;
        w0 = wcount; d0 = done_cnt; hit = 1'b0; auto_rsp = 1'b1; bus.in_valid = 1'b1;
        do_start(64'h30000, 32'd6, 64'h8140);
        for (int i = 0; i < 100 && !hit; i++) begin
            tick();
            if (wcount - w0 >= 3) hit = 1'b1;
        end
        n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL rmid_three_writes got %b want 1", hit); end
        reset = 1'b1; auto_rsp = 1'b0;
        tick(); tick();
        rsp_floor = wcount;
        reset = 1'b0;
        stray_total += 3;
        repeat (8) tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b want 0", busy); end
        n_cmp++; if (dut.r_outstanding !== 2'd0) begin n_err++; $display("FAIL rmid_outstanding got %0d want 0", dut.r_outstanding); end
        n_cmp++; if (done_cnt != d0) begin n_err++; $display("FAIL rmid_no_done got %0d want %0d", done_cnt, d0); end
        w0 = wcount; auto_rsp = 1'b1;
        do_start(64'h40000, 32'd2, 64'h8180);
        wait_done(d0, 100, ok);
        bus.in_valid = 1'b0;
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rmid_restart_done got %b want 1", ok); end
        n_cmp++; if (wcount - w0 != 3) begin n_err++; $display("FAIL rmid_restart_count got %0d want 3", wcount - w0); end
        if (wcount - w0 == 3) begin
            n_cmp++; if (wa[w0] !== 42'h1000 || wa[w0+1] !== 42'h1001) begin n_err++; $display("FAIL rmid_restart_addr got %h,%h want 1000,1001", wa[w0], wa[w0+1]); end
            n_cmp++; if (wa[w0+2] !== 42'h206 || wd[w0+2][63:0] !== 64'h0000_0002_0000_0001) begin n_err++; $display("FAIL rmid_restart_dsm got %h/%h want 206/0000000200000001", wa[w0+2], wd[w0+2][63:0]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_size_zero();
        test_af_toggle();
        test_max_outstanding();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got timeout want completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
